seq_pattern_tx: RTL and testbench

Serial frame transmitter, the generating counterpart to the team's serial sequence detectors. It accepts a parallel payload word on a valid/ready handshake and drives one serial bit line, x_out, one bit per clk. Each frame is a fixed sync pattern sent MSB-first, then the payload sent MSB-first, then a low inter-frame gap. It sits upstream of any detector or deserializer on the same single-wire link.

---
 rtl/seq_pattern_tx_pkg.sv | 25 ++
 rtl/seq_pattern_tx_if.sv | 13 +
 rtl/seq_pattern_tx.sv | 144 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial sequence transmitter and its matching detectors:
// FSM state encoding, default sync pattern, and the frame counter width helper.
package seq_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_e;

  localparam int          SYNC_W_DEF   = 3;
  localparam logic [2:0]  SYNC_PAT_DEF = 3'b101;

  // Bits needed for a down-counter that must hold the longest phase length.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Payload handshake bundle between a word producer and the serial transmitter.
// A word moves on a rising clk edge where in_valid && in_ready; in_data only matters at that edge.
interface seq_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, optional even parity, low gap.
// Define SEQ_TX_PARITY_EN to append one even-parity bit after the payload.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEF,
  parameter int                GAP_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst,
  seq_tx_if.slave in_if,
  output logic   x_out,
  output logic   busy,
  output logic   frame_done,
  output state_e state_o
);

  localparam int SH_W  = SYNC_W + DATA_W;
  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_CYCLES);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [SH_W-1:0]  load_w;
  logic             x_out_q, x_out_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             accept_w;
`ifdef SEQ_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign accept_w       = in_if.in_valid && (state_q == IDLE);
  assign in_if.in_ready = (state_q == IDLE) && !rst;

  // x_out is registered, so each edge loads the bit for the cycle that follows;
  // the bit produced on a phase's last edge therefore belongs to the next phase.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    x_out_d      = 1'b0;
    frame_done_d = 1'b0;
    load_w       = {SYNC_PAT, in_if.in_data};
`ifdef SEQ_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          state_d = SYNC;
          cnt_d   = CNT_SYNC;
          x_out_d = SYNC_PAT[SYNC_W-1];
          sh_d    = load_w << 1;
`ifdef SEQ_TX_PARITY_EN
          par_d   = ^in_if.in_data;
`endif
        end
      end
      SYNC: begin
        x_out_d = sh_q[SH_W-1];
        sh_d    = sh_q << 1;
        if (cnt_q == CNT_ONE) begin
          state_d = DATA;
          cnt_d   = CNT_DATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_ONE) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = PAR;
          cnt_d   = CNT_ONE;
          x_out_d = par_q;
`else
          state_d      = GAP;
          cnt_d        = CNT_GAP;
          frame_done_d = 1'b1;
`endif
        end else begin
          x_out_d = sh_q[SH_W-1];
          sh_d    = sh_q << 1;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      PAR: begin
        state_d      = GAP;
        cnt_d        = CNT_GAP;
        frame_done_d = 1'b1;
      end
      GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      x_out_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      x_out_q      <= x_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef SEQ_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign x_out      = x_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: default-parameter instance with a per-cycle scoreboard,
// plus a narrow instance (1-bit sync/data, 3-cycle gap) checked over held-valid frames.
module tb_seq_pattern_tx;
  import seq_tx_pkg::*;

  localparam logic [2:0] TB_SYNC = 3'b101;
`ifdef SEQ_TX_PARITY_EN
  localparam int SW_F = 3;
`else
  localparam int SW_F = 2;
`endif
  localparam int SW_P = SW_F + 3 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_tx_if #(.DATA_W(8)) bus ();
  seq_tx_if #(.DATA_W(1)) bus2 ();

  logic   x_out, busy, frame_done;
  logic   x2, busy2, fd2;
  state_e st, st2;

  seq_pattern_tx #(.DATA_W(8), .SYNC_W(3), .SYNC_PAT(3'b101), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_if(bus),
    .x_out(x_out), .busy(busy), .frame_done(frame_done), .state_o(st)
  );

  seq_pattern_tx #(.DATA_W(1), .SYNC_W(1), .SYNC_PAT(1'b1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst2), .in_if(bus2),
    .x_out(x2), .busy(busy2), .frame_done(fd2), .state_o(st2)
  );

  // Expected per-cycle outputs of dut: {x_out, frame_done, busy, in_ready}
  logic [3:0] exp_q[$];
  logic [3:0] e_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 2; i >= 0; i--) exp_q.push_back({TB_SYNC[i], 3'b010});
    for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 3'b010});
`ifdef SEQ_TX_PARITY_EN
    exp_q.push_back({^d, 3'b010});
`endif
    exp_q.push_back(4'b0110);
  endtask

  // Called and returning at #1 after a rising edge.
  task automatic send_frame(input logic [7:0] d, input bit keep_valid);
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    push_frame(d);
    #1;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      e_m = (exp_q.size() != 0) ? exp_q.pop_front() : {3'b000, ~rst};
      check("x_out", {31'd0, x_out}, {31'd0, e_m[3]});
      check("frame_done", {31'd0, frame_done}, {31'd0, e_m[2]});
      check("busy", {31'd0, busy}, {31'd0, e_m[1]});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, e_m[0]});
    end
  end

  task automatic main_seq();
    send_frame(8'hA5, 1'b0);
    send_frame(8'h07, 1'b0);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (8) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    send_frame(8'hC3, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'h5A, 1'b0);
    repeat (4) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_frame(8'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic sweep_seq();
    logic       d;
    logic [3:0] e;
    d = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    for (int f = 0; f < 4; f++) begin
      @(posedge clk);
      for (int j = 0; j < SW_P; j++) begin
        @(negedge clk);
        if (j < SW_F)      e = {(j == 0) ? 1'b1 : d, 3'b010};
        else if (j == SW_F) e = 4'b0110;
        else if (j < SW_F + 3) e = 4'b0010;
        else               e = 4'b0001;
        check("sw_x_out", {31'd0, x2}, {31'd0, e[3]});
        check("sw_frame_done", {31'd0, fd2}, {31'd0, e[2]});
        check("sw_busy", {31'd0, busy2}, {31'd0, e[1]});
        check("sw_in_ready", {31'd0, bus2.in_ready}, {31'd0, e[0]});
      end
      d = ~d;
      bus2.in_data = d;
      if (f == 3) bus2.in_valid = 1'b0;
    end
    @(negedge clk);
    check("sw_idle_x", {31'd0, x2}, 32'd0);
    check("sw_idle_busy", {31'd0, busy2}, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus2.in_valid = 1'b0;
    bus2.in_data  = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;
    fork
      main_seq();
      sweep_seq();
    join
    repeat (20) @(posedge clk);
    check("drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
